// File: rtl/button_cmd_gen_if.sv
// Raw push-button inputs and the command strobes produced from them.
interface button_cmd_gen_if;
    logic [4:0] BTN;
    logic       L;
    logic       INC;
    logic       DEC;
    logic       SHL;
    logic       SHR;

    // The board/button side drives BTN and observes the strobes.
    modport master (output BTN, input L, INC, DEC, SHL, SHR);
    // The command generator samples BTN and drives the strobes.
    modport slave  (input BTN, output L, INC, DEC, SHL, SHR);
endinterface

// File: rtl/button_cmd_gen.sv
// Button conditioning for the load/shift/count register: synchronise,
// debounce and edge-detect five buttons, auto-repeat INC/DEC while held,
// and arbitrate everything down to at most one registered strobe per cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no auto-repeat in progress
// DELAY  | INC/DEC press strobe issued, waiting for the first repeat
// REPEAT | owner still held, issuing a repeat strobe every period
module button_cmd_gen #(
    parameter int unsigned DB_CYCLES      = 1000000,
    parameter int unsigned RPT_DELAY      = 25000000,
    parameter int unsigned RPT_PERIOD     = 5000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input logic             C,
    input logic             R,
    button_cmd_gen_if.slave bus
);
    // Debounce counter only ever needs to hold DB_CYCLES-1.
    localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RW = $clog2(RPT_MAX);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LOAD = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(RPT_PERIOD - 1);
    // Raw level that a released button presents on the pins.
    localparam logic [4:0] RAW_IDLE = BTN_ACTIVE_LOW ? 5'b11111 : 5'b00000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } rpt_state_t;

    logic [4:0]     sync_a;
    logic [4:0]     sync_b;
    logic [4:0]     level;
    logic [4:0]     db;
    logic [4:0]     db_d;
    logic [4:0]     press;
    logic [DBW-1:0] db_cnt [5];

    rpt_state_t     state;
    rpt_state_t     nxt_state;
    logic           owner;       // 0 = INC, 1 = DEC
    logic           nxt_owner;
    logic [RW-1:0]  rpt_cnt;
    logic [RW-1:0]  nxt_cnt;
    logic           owner_held;
    logic [4:0]     cmd;
    logic [4:0]     cmd_nxt;

    // Two-flop synchroniser on the raw pins, reset to the released level.
    always_ff @(posedge C) begin
        if (R) begin
            sync_a <= RAW_IDLE;
            sync_b <= RAW_IDLE;
        end else begin
            sync_a <= bus.BTN;
            sync_b <= sync_a;
        end
    end

    assign level = BTN_ACTIVE_LOW ? ~sync_b : sync_b;

    // Per-bit debounce: the state follows the synced level only after it has
    // disagreed for DB_CYCLES consecutive cycles; db_d feeds the press detector.
    always_ff @(posedge C) begin
        if (R) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_d <= db;
            for (int i = 0; i < 5; i++) begin
                if (level[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press candidates: debounced rising edges only; releases are ignored.
    assign press = db & ~db_d;

    // Repeat FSM state, owner and down-counting repeat timer.
    always_ff @(posedge C) begin
        if (R) begin
            state   <= S_IDLE;
            owner   <= 1'b0;
            rpt_cnt <= '0;
        end else begin
            state   <= nxt_state;
            owner   <= nxt_owner;
            rpt_cnt <= nxt_cnt;
        end
    end

    // Fixed-priority arbitration L > INC > DEC > SHL > SHR > repeat, plus the
    // repeat FSM transitions driven by whichever strobe wins.
    always_comb begin
        nxt_state  = state;
        nxt_owner  = owner;
        nxt_cnt    = rpt_cnt;
        cmd_nxt    = '0;
        owner_held = owner ? db[2] : db[1];

        if (state != S_IDLE && rpt_cnt != '0) begin
            nxt_cnt = rpt_cnt - 1'b1;
        end

        if (press[0]) begin
            cmd_nxt[0] = 1'b1;
            nxt_state  = S_IDLE;
        end else if (press[1]) begin
            cmd_nxt[1] = 1'b1;
            nxt_state  = S_DELAY;
            nxt_owner  = 1'b0;
            nxt_cnt    = DELAY_LOAD;
        end else if (press[2]) begin
            cmd_nxt[2] = 1'b1;
            nxt_state  = S_DELAY;
            nxt_owner  = 1'b1;
            nxt_cnt    = DELAY_LOAD;
        end else if (press[3]) begin
            cmd_nxt[3] = 1'b1;
            nxt_state  = S_IDLE;
        end else if (press[4]) begin
            cmd_nxt[4] = 1'b1;
            nxt_state  = S_IDLE;
        end else if (state != S_IDLE) begin
            if (!owner_held) begin
                nxt_state = S_IDLE;
            end else if (rpt_cnt == '0) begin
                // Timer expiry in DELAY or REPEAT both issue a repeat and
                // reload with the period.
                cmd_nxt[owner ? 2 : 1] = 1'b1;
                nxt_state = S_REPEAT;
                nxt_cnt   = PERIOD_LOAD;
            end
        end
    end

    // Registered strobes so every output is glitch-free and one cycle wide.
    always_ff @(posedge C) begin
        if (R) begin
            cmd <= '0;
        end else begin
            cmd <= cmd_nxt;
        end
    end

    assign bus.L   = cmd[0];
    assign bus.INC = cmd[1];
    assign bus.DEC = cmd[2];
    assign bus.SHL = cmd[3];
    assign bus.SHR = cmd[4];
endmodule
